// File: rtl/button_conditioner.sv
// Button conditioner: synchronises and debounces four colour buttons and a
// start button, then turns the debounced colours into one accepted colour
// code per physical press for the game controller.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       START_BTN,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       START_GAME,
  output logic [3:0] BTN_DB
);

  localparam int unsigned NUM_COLOURS = 4;
  localparam int unsigned NUM_INPUTS  = NUM_COLOURS + 1;
  localparam int unsigned START_IDX   = NUM_COLOURS;

  // Counter value on which a pending level change is committed
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  // Raw inputs gathered into one vector: colours in [3:0], start on top
  logic [NUM_INPUTS-1:0] raw;
  logic [NUM_INPUTS-1:0] sync_meta;
  logic [NUM_INPUTS-1:0] sync_q;

  // Debounced levels and per-input stability counters
  logic [NUM_INPUTS-1:0] db_q;
  logic [NUM_INPUTS-1:0] db_nxt;
  logic [CNT_W-1:0]      cnt_q   [NUM_INPUTS];
  logic [CNT_W-1:0]      cnt_nxt [NUM_INPUTS];

  // Colour press FSM
  logic [1:0]             state_q;
  logic [1:0]             state_nxt;
  logic [1:0]             in_nxt;
  logic                   valid_nxt;
  logic [NUM_COLOURS-1:0] colour_db;
  logic                   colour_one_hot;
  logic [1:0]             colour_code;

  assign raw = {START_BTN, BTN};

  // Two-flop synchroniser for every raw input
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Debounce: a level change commits only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreeing cycle restarts the count
  always_comb begin
    db_nxt = db_q;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      cnt_nxt[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_nxt[i] = sync_q[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      db_q <= '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q  <= db_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign colour_db      = db_q[NUM_COLOURS-1:0];
  assign colour_one_hot = (colour_db != '0) &&
                          ((colour_db & (colour_db - 4'd1)) == '0);

  // Encode the single set colour bit; only meaningful when one-hot
  always_comb begin
    colour_code = 2'd0;
    case (colour_db)
      4'b0001: colour_code = 2'd0;
      4'b0010: colour_code = 2'd1;
      4'b0100: colour_code = 2'd2;
      4'b1000: colour_code = 2'd3;
      default: colour_code = 2'd0;
    endcase
  end

  // Press FSM next state and next outputs; IN holds unless a press is taken
  always_comb begin
    state_nxt = state_q;
    in_nxt    = IN;
    valid_nxt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (colour_one_hot) begin
          in_nxt    = colour_code;
          valid_nxt = 1'b1;
          state_nxt = ST_PRESSED;
        end else if (colour_db != '0) begin
          state_nxt = ST_LOCKOUT;
        end
      end
      ST_PRESSED: begin
        if (colour_db[IN]) begin
          valid_nxt = 1'b1;
        end else if (colour_db == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (colour_db == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Registered colour outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IN       <= 2'd0;
      IN_VALID <= 1'b0;
    end else begin
      IN       <= in_nxt;
      IN_VALID <= valid_nxt;
    end
  end

  assign START_GAME = db_q[START_IDX];
  assign BTN_DB     = db_q[NUM_COLOURS-1:0];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed test-plan steps followed by random
// button activity, all checked against a behavioural model.
module tb_button_conditioner;

  localparam int unsigned DC = 4;
  localparam int unsigned CW = 3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BTN;
  logic       START_BTN;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       START_GAME;
  logic [3:0] BTN_DB;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: history of raw samples plus abstract press bookkeeping
  logic [4:0] m_hist [$];
  logic [4:0] m_db;
  logic       m_active;
  logic       m_blocked;
  logic [1:0] m_in;
  logic       m_valid;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BTN       (BTN),
    .START_BTN (START_BTN),
    .IN        (IN),
    .IN_VALID  (IN_VALID),
    .START_GAME(START_GAME),
    .BTN_DB    (BTN_DB)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < int'(DC) + 2; k++) m_hist.push_back(5'd0);
    m_db      = 5'd0;
    m_active  = 1'b0;
    m_blocked = 1'b0;
    m_in      = 2'd0;
    m_valid   = 1'b0;
  endtask

  // One clock edge of the model
  task automatic model_edge();
    logic [3:0] d;
    logic [4:0] smp;
    bit         flip;
    d       = m_db[3:0];
    m_valid = 1'b0;
    if (m_active) begin
      if (d[m_in]) m_valid = 1'b1;
      else begin
        m_active  = 1'b0;
        m_blocked = (d != 4'd0);
      end
    end else if (m_blocked) begin
      if (d == 4'd0) m_blocked = 1'b0;
    end else if ($countones(d) == 1) begin
      for (int k = 0; k < 4; k++) if (d[k]) m_in = 2'(k);
      m_active = 1'b1;
      m_valid  = 1'b1;
    end else if (d != 4'd0) begin
      m_blocked = 1'b1;
    end
    // A debounced level flips once the synchronised input (raw delayed two
    // edges) has disagreed with it for DC consecutive samples
    m_hist.push_back({START_BTN, BTN});
    for (int b = 0; b < 5; b++) begin
      flip = 1'b1;
      for (int j = 2; j <= int'(DC) + 1; j++) begin
        smp = m_hist[m_hist.size() - 1 - j];
        if (smp[b] == m_db[b]) flip = 1'b0;
      end
      if (flip) m_db[b] = ~m_db[b];
    end
    while (m_hist.size() > int'(DC) + 2) void'(m_hist.pop_front());
  endtask

  task automatic compare_model();
    check("in_valid", 32'(IN_VALID), 32'(m_valid));
    check("in", 32'(IN), 32'(m_in));
    check("start_game", 32'(START_GAME), 32'(m_db[4]));
    check("btn_db", 32'(BTN_DB), 32'(m_db[3:0]));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic ticks_valid(input int n, input logic v, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      check(tag, 32'(IN_VALID), 32'(v));
    end
  endtask

  // Async reset pulse between clock edges; outputs must clear at once
  task automatic async_reset_pulse();
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    check("rst_in_valid", 32'(IN_VALID), 32'd0);
    check("rst_in", 32'(IN), 32'd0);
    check("rst_start", 32'(START_GAME), 32'd0);
    check("rst_btn_db", 32'(BTN_DB), 32'd0);
    #1 RST_N = 1'b1;
  endtask

  initial begin
    RST_N     = 1'b0;
    BTN       = 4'd0;
    START_BTN = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_in_valid", 32'(IN_VALID), 32'd0);
    check("reset_in", 32'(IN), 32'd0);
    check("reset_start", 32'(START_GAME), 32'd0);
    check("reset_btn_db", 32'(BTN_DB), 32'd0);
    RST_N = 1'b1;
    ticks(3);

    // Clean single press of colour 2
    BTN = 4'b0100;
    ticks_valid(6, 1'b0, "clean_pre");
    tick();
    check("clean_rise", 32'(IN_VALID), 32'd1);
    check("clean_in", 32'(IN), 32'd2);
    ticks(13);
    BTN = 4'b0000;
    ticks_valid(6, 1'b1, "clean_hold");
    tick();
    check("clean_fall", 32'(IN_VALID), 32'd0);
    check("clean_in_kept", 32'(IN), 32'd2);
    ticks(5);

    // Bounce on colour 1, then held
    for (int p = 0; p < 2; p++) begin
      BTN = 4'b0010;
      ticks_valid(2, 1'b0, "bounce_hi");
      BTN = 4'b0000;
      ticks_valid(2, 1'b0, "bounce_lo");
    end
    BTN = 4'b0010;
    ticks_valid(6, 1'b0, "bounce_settle");
    tick();
    check("bounce_rise", 32'(IN_VALID), 32'd1);
    check("bounce_in", 32'(IN), 32'd1);
    ticks(5);
    BTN = 4'b0000;
    ticks(10);

    // Chord is rejected; the next clean press is accepted
    BTN = 4'b1001;
    ticks_valid(12, 1'b0, "chord_held");
    BTN = 4'b0000;
    ticks_valid(10, 1'b0, "chord_release");
    BTN = 4'b1000;
    ticks_valid(6, 1'b0, "chord_next_pre");
    tick();
    check("chord_next_rise", 32'(IN_VALID), 32'd1);
    check("chord_next_in", 32'(IN), 32'd3);
    BTN = 4'b0000;
    ticks(10);

    // Overlapping presses: first one wins, second one never accepted
    BTN = 4'b0001;
    ticks(10);
    check("ovl_first", 32'(IN_VALID), 32'd1);
    BTN = 4'b0101;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("ovl_in_frozen", 32'(IN), 32'd0);
      check("ovl_valid_held", 32'(IN_VALID), 32'd1);
    end
    BTN = 4'b0100;
    ticks_valid(6, 1'b1, "ovl_release_pre");
    tick();
    check("ovl_fall", 32'(IN_VALID), 32'd0);
    check("ovl_fall_in", 32'(IN), 32'd0);
    ticks_valid(10, 1'b0, "ovl_lockout");
    BTN = 4'b0000;
    ticks_valid(10, 1'b0, "ovl_idle");
    BTN = 4'b0100;
    ticks(7);
    check("ovl_repress", 32'(IN_VALID), 32'd1);
    check("ovl_repress_in", 32'(IN), 32'd2);
    BTN = 4'b0000;
    ticks(10);

    // Start path: latency, glitch rejection, independence from colours
    START_BTN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("start_pre", 32'(START_GAME), 32'd0);
    end
    tick();
    check("start_rise", 32'(START_GAME), 32'd1);
    ticks(4);
    START_BTN = 1'b0;
    ticks(2);
    START_BTN = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("start_glitch", 32'(START_GAME), 32'd1);
      check("start_no_colour", 32'(IN_VALID), 32'd0);
    end
    START_BTN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("start_hold", 32'(START_GAME), 32'd1);
    end
    tick();
    check("start_fall", 32'(START_GAME), 32'd0);
    ticks(4);

    // Reset in the middle of an accepted press
    BTN = 4'b0010;
    ticks(10);
    check("rstmid_valid", 32'(IN_VALID), 32'd1);
    async_reset_pulse();
    ticks_valid(6, 1'b0, "rstmid_pre");
    tick();
    check("rstmid_rise", 32'(IN_VALID), 32'd1);
    check("rstmid_in", 32'(IN), 32'd1);
    BTN = 4'b0000;
    ticks(10);

    // Random activity against the model
    for (int s = 0; s < 250; s++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind <= 4)      BTN = 4'b0001 << $urandom_range(0, 3);
      else if (kind <= 6) BTN = 4'b0000;
      else if (kind == 7) BTN = 4'($urandom);
      else if (kind == 8) BTN = BTN | (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) START_BTN = ~START_BTN;
      if ($urandom_range(0, 59) == 0) async_reset_pulse();
      ticks(int'($urandom_range(1, 12)));
    end

    BTN       = 4'b0000;
    START_BTN = 1'b0;
    ticks(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage of the game controller: turns raw, asynchronous, bouncy push-button inputs into clean controller-facing signals.
- Conditions four colour buttons and one start button.
- Drives the controller's colour input bus (IN/IN_VALID) and START_GAME level.
- Guarantees one colour code per physical press, held stable for the whole press; multi-button presses are rejected.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clock cycles required before a debounced level changes (10 ms at 25 MHz); must be >= 2.
- CNT_W, 18: width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; single clock domain.
- RST_N  input  1  asynchronous active-low reset.
- BTN  input  4  raw colour buttons, active-high, asynchronous to CLK; BTN[k] means colour code k.
- START_BTN  input  1  raw start button, active-high, asynchronous.
- IN  output  2  encoded colour of the accepted press.
- IN_VALID  output  1  high while the accepted colour button is held.
- START_GAME  output  1  debounced start-button level.
- BTN_DB  output  4  debounced colour levels (status/LED use).

Behaviour:
Interface and reset:
- One clock, CLK.
- RST_N is asynchronous assert, active-low; all flops clear on assertion.
- Outputs at reset: IN=0, IN_VALID=0, START_GAME=0, BTN_DB=0.
- Synchronisers, debounce counters and FSM state also reset (FSM to IDLE).
- Reset mid-press: outputs drop immediately. After release of reset, a held button is re-detected as a fresh press after full sync + debounce latency.

Synchronisation:
- 2-FF synchroniser per input (5 total), reset to 0.

Debounce (per input, 5 instances):
- Each instance holds a stable level db and a counter cnt.
- If sync != db: cnt increments; when cnt reaches DEBOUNCE_CYCLES-1, db <= sync and cnt <= 0.
- If sync == db: cnt <= 0, so any glitch restarts the count.
- Latency from input edge to db change: 2 (sync) + DEBOUNCE_CYCLES cycles.
- Pulses shorter than DEBOUNCE_CYCLES never propagate.

Outputs from debounce:
- START_GAME = db of start (registered, no extra latency).
- BTN_DB = db of colours.

Colour FSM (states IDLE, PRESSED, LOCKOUT), evaluated on debounced colours d[3:0]:
- IDLE:
  - d exactly one-hot: IN <= index of the set bit, IN_VALID <= 1, go to PRESSED. IN_VALID rises the cycle after d becomes one-hot.
  - d == 0: stay, IN_VALID=0.
  - d has >=2 bits set (including simultaneous arrival): no press accepted; go to LOCKOUT.
- PRESSED:
  - IN is frozen.
  - d[IN]=1: stay, IN_VALID=1. Extra buttons pressed meanwhile are ignored.
  - d[IN]=0: IN_VALID <= 0. Go to IDLE if d==0; otherwise go to LOCKOUT.
  - IN keeps its last value after release and is not cleared.
- LOCKOUT:
  - IN_VALID=0.
  - Stay until d==0, then go to IDLE.
  - The next press after leaving is accepted normally.
- Illegal state encoding returns to IDLE with IN_VALID=0.

Guarantees and independence:
- Exactly one IN_VALID rising edge per accepted press.
- IN is stable whenever IN_VALID=1.
- Start and colour paths are independent: START_GAME does not affect the FSM.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean single press: after reset, BTN=4'b0100 for 20 cycles, then 0. Required:
  - IN_VALID rises 7 cycles after the edge (2 sync + 4 debounce + 1 FSM), with IN=2.
  - IN_VALID falls 7 cycles after release.
  - IN stays 2.
- Bounce rejection: BTN[1] toggled 1,0,1,0 with 2-cycle pulses, then held. Required:
  - No IN_VALID during bounce.
  - Exactly one rising edge, with IN=1, 7 cycles after the final stable edge.
- Chord: BTN=4'b1001 asserted in the same cycle. Required:
  - IN_VALID stays 0 throughout.
  - After release to 0, a press of BTN[3] yields IN=3, IN_VALID=1.
- Overlap: hold BTN[0], then BTN[2] pressed, then BTN[0] released while BTN[2] is held. Required:
  - IN=0 throughout, and IN_VALID falls on release of BTN[0].
  - No new IN_VALID until BTN[2] is released and pressed again.
- Start path: START_BTN held 10 cycles, then a 2-cycle glitch. Required:
  - START_GAME rises 6 cycles after the edge.
  - The glitch is ignored.
  - START_GAME falls 6 cycles after release.
  - IN_VALID is unaffected.
- Reset mid-press: with IN_VALID=1, pulse RST_N low asynchronously between clock edges while the button stays held. Required:
  - Outputs go to 0 immediately.
  - IN_VALID reasserts 7 cycles after reset deassertion.
